// File: rtl/anubis_pkg.sv
// rtl/anubis_pkg.sv - shared tables, mode and state encodings for the ANUBIS mini-box layer
package anubis_pkg;

  localparam logic MODE_P = 1'b0;
  localparam logic MODE_Q = 1'b1;

  // Packed so that TABLE[n] is the image of nibble n.
  localparam logic [15:0][3:0] P_TABLE = 64'h128769ADCB450EF3;
  localparam logic [15:0][3:0] Q_TABLE = 64'h81B7D40FC32A65E9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/anubis_minibox.sv
// rtl/anubis_minibox.sv - single 4-bit P/Q mini-box lookup
module anubis_minibox
  import anubis_pkg::*;
(
  input  logic       mode_i,
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (mode_i == MODE_Q) ? Q_TABLE[nib_i] : P_TABLE[nib_i];

endmodule

// File: rtl/anubis_minibox_layer.sv
// rtl/anubis_minibox_layer.sv - iterative nibble-substitution layer, LANES nibbles per clock
module anubis_minibox_layer
  import anubis_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int LN   = (LANES < 1) ? 1 : LANES;
  localparam int SW   = 4 * LN;
  localparam int ITER = WIDTH / SW;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  if ((LANES < 1) || (WIDTH % SW != 0)) begin : g_bad_params
    $error("anubis_minibox_layer: WIDTH must be a multiple of 4*LANES and LANES >= 1");
  end

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             mode_q;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    sub;
  logic [WIDTH-1:0] shifted;

  for (genvar i = 0; i < LN; i++) begin : g_lane
    anubis_minibox u_box (
      .mode_i (mode_q),
      .nib_i  (data_q[4*i +: 4]),
      .nib_o  (sub[4*i +: 4])
    );
  end

  // Results enter at the top, so after ITER rotations every nibble is back in place.
  if (ITER == 1) begin : g_single
    assign shifted = sub;
  end else begin : g_multi
    assign shifted = {sub, data_q[WIDTH-1:SW]};
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= MODE_P;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            mode_q  <= in_mode;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          data_q <= shifted;
          if (cnt_q == CW'(ITER - 1)) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              data_q  <= in_data;
              mode_q  <= in_mode;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anubis_minibox_layer.sv
// tb/tb_anubis_minibox_layer.sv - self-checking bench for anubis_minibox_layer over four configurations
module tb_anubis_minibox_layer;

  localparam int NCFG = 4;
  localparam int CFG_W [NCFG] = '{64, 64, 64, 128};
  localparam int CFG_L [NCFG] = '{4, 1, 16, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid_a  [NCFG];
  logic         in_ready_a  [NCFG];
  logic [127:0] in_data_a   [NCFG];
  logic         in_mode_a   [NCFG];
  logic         out_valid_a [NCFG];
  logic         out_ready_a [NCFG];
  logic [127:0] out_data_a  [NCFG];
  logic         busy_a      [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int WG = CFG_W[g];
    localparam int LG = CFG_L[g];
    logic          ir, ov, bz;
    logic [WG-1:0] od;
    anubis_minibox_layer #(.WIDTH(WG), .LANES(LG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (ir),
      .in_data   (in_data_a[g][WG-1:0]),
      .in_mode   (in_mode_a[g]),
      .out_valid (ov),
      .out_ready (out_ready_a[g]),
      .out_data  (od),
      .busy      (bz)
    );
    assign in_ready_a[g]  = ir;
    assign out_valid_a[g] = ov;
    assign busy_a[g]      = bz;
    assign out_data_a[g]  = 128'(od);
  end

  logic [3:0] P_T [16] = '{4'h3, 4'hF, 4'hE, 4'h0, 4'h5, 4'h4, 4'hB, 4'hC,
                           4'hD, 4'hA, 4'h9, 4'h6, 4'h7, 4'h8, 4'h2, 4'h1};
  logic [3:0] Q_T [16] = '{4'h9, 4'hE, 4'h5, 4'h6, 4'hA, 4'h2, 4'h3, 4'hC,
                           4'hF, 4'h0, 4'h4, 4'hD, 4'h7, 4'hB, 4'h1, 4'h8};

  int checks = 0;
  int errors = 0;

  function automatic logic [127:0] model(input logic [127:0] d, input int w, input logic m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < w / 4; i++) begin
      r[i*4 +: 4] = m ? Q_T[d[i*4 +: 4]] : P_T[d[i*4 +: 4]];
    end
    return r;
  endfunction

  task automatic run_word(input int g, input logic [127:0] d, input logic m,
                          output logic [127:0] got, output int lat);
    in_data_a[g]  = d;
    in_mode_a[g]  = m;
    in_valid_a[g] = 1'b1;
    checks++;
    if (in_ready_a[g] !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_idle cfg%0d: got %b want 1", g, in_ready_a[g]);
    end
    @(posedge clk); #1;
    in_valid_a[g] = 1'b0;
    in_data_a[g]  = {$urandom, $urandom, $urandom, $urandom};
    in_mode_a[g]  = ~m;
    lat = 0;
    while (out_valid_a[g] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    got = out_data_a[g];
    out_ready_a[g] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[g] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      checks++;
      if (out_valid_a[g] !== 1'b0 || busy_a[g] !== 1'b0 || in_ready_a[g] !== 1'b1 || out_data_a[g] !== '0) begin
        errors++;
        $display("FAIL reset_state cfg%0d: got ov=%b busy=%b ir=%b od=%h want ov=0 busy=0 ir=1 od=0",
                 g, out_valid_a[g], busy_a[g], in_ready_a[g], out_data_a[g]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [127:0] got;
    int lat;
    run_word(0, 128'h0123456789ABCDEF, 1'b0, got, lat);
    checks++;
    if (got !== 128'h3FE054BCDA967821) begin
      errors++; $display("FAIL vec_p: got %h want 3fe054bcda967821", got);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL vec_p_latency: got %0d want 4", lat); end
    run_word(0, 128'h0123456789ABCDEF, 1'b1, got, lat);
    checks++;
    if (got !== 128'h9E56A23CF04D7B18) begin
      errors++; $display("FAIL vec_q: got %h want 9e56a23cf04d7b18", got);
    end
    run_word(0, got, 1'b1, got, lat);
    checks++;
    if (got !== 128'h0123456789ABCDEF) begin
      errors++; $display("FAIL vec_q_involution: got %h want 0123456789abcdef", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] held, got;
    int lat;
    in_data_a[0] = 128'h0123456789ABCDEF; in_mode_a[0] = 1'b0; in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    lat = 0;
    while (out_valid_a[0] !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    held = out_data_a[0];
    checks++;
    if (held !== 128'h3FE054BCDA967821) begin
      errors++; $display("FAIL hold_first: got %h want 3fe054bcda967821", held);
    end
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_a[0] !== 1'b1 || out_data_a[0] !== held || in_ready_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: got ov=%b od=%h ir=%b want ov=1 od=%h ir=0",
                 out_valid_a[0], out_data_a[0], in_ready_a[0], held);
      end
    end
    out_ready_a[0] = 1'b1;
    in_valid_a[0]  = 1'b1; in_data_a[0] = 128'hFFFFFFFFFFFFFFFF; in_mode_a[0] = 1'b0;
    #1;
    checks++;
    if (in_ready_a[0] !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready_a[0]); end
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0; out_ready_a[0] = 1'b0;
    checks++;
    if (busy_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_busy: got busy=%b ov=%b want busy=1 ov=0", busy_a[0], out_valid_a[0]);
    end
    lat = 0;
    while (out_valid_a[0] !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    got = out_data_a[0];
    checks++;
    if (got !== 128'h1111111111111111 || lat !== 4) begin
      errors++; $display("FAIL b2b_result: got %h lat %0d want 1111111111111111 lat 4", got, lat);
    end
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit stale;
    in_data_a[0] = 128'h0123456789ABCDEF; in_mode_a[0] = 1'b0; in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1 || out_data_a[0] !== '0) begin
      errors++;
      $display("FAIL reset_mid: got ov=%b busy=%b ir=%b od=%h want ov=0 busy=0 ir=1 od=0",
               out_valid_a[0], busy_a[0], in_ready_a[0], out_data_a[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin errors++; $display("FAIL reset_no_stale: got a stale busy/out_valid, want none"); end
  endtask

  task automatic test_sweep();
    logic [127:0] d, got, want;
    logic m;
    int lat;
    for (int g = 0; g < NCFG; g++) begin
      for (int n = 0; n < 6; n++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        m = n[0];
        want = model(d, CFG_W[g], m);
        run_word(g, d, m, got, lat);
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL sweep_data cfg%0d mode %b: got %h want %h", g, m, got, want);
        end
        checks++;
        if (lat !== CFG_W[g] / (4 * CFG_L[g])) begin
          errors++; $display("FAIL sweep_latency cfg%0d: got %0d want %0d", g, lat, CFG_W[g] / (4 * CFG_L[g]));
        end
        checks++;
        if (out_valid_a[g] !== 1'b0) begin
          errors++; $display("FAIL sweep_release cfg%0d: got ov=%b want 0", g, out_valid_a[g]);
        end
      end
    end
  endtask

  initial begin
    for (int g = 0; g < NCFG; g++) begin
      in_valid_a[g] = 1'b0; in_data_a[g] = '0; in_mode_a[g] = 1'b0; out_ready_a[g] = 1'b0;
    end
    #2;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
